// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans a 24-bit value as 6 hex digits across an 8-digit
// multiplexed 7-segment display (active-low anodes and cathodes). The value
// is latched once per frame so a digit never tears. Blink and leading-zero
// suppression are supported.
//
// Blink phase FSM:
//   state  | meaning
//   PH_ON  | digits driven normally
//   PH_OFF | all anodes and cathodes forced dark, scan keeps running
module seg_scan_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] seg_value,
  input  logic        blink_en,
  input  logic        blank_lz,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_ca,
  output logic        frame_done
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_HALF - 1);

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } phase_t;

  logic [SW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [23:0]   shadow;
  logic [BW-1:0] blink_cnt;
  phase_t        phase;
  phase_t        phase_nxt;
  logic          scan_tc;
  logic          blink_tc;
  logic          disp_on;
  logic [3:0]    nibble;
  logic          lz_dark;
  logic [7:0]    an_nxt;
  logic [7:0]    ca_nxt;

  function automatic logic [7:0] hex_ca(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'h0: c = 8'hC0;
      4'h1: c = 8'hF9;
      4'h2: c = 8'hA4;
      4'h3: c = 8'hB0;
      4'h4: c = 8'h99;
      4'h5: c = 8'h92;
      4'h6: c = 8'h82;
      4'h7: c = 8'hF8;
      4'h8: c = 8'h80;
      4'h9: c = 8'h90;
      4'hA: c = 8'h88;
      4'hB: c = 8'h83;
      4'hC: c = 8'hC6;
      4'hD: c = 8'hA1;
      4'hE: c = 8'h86;
      default: c = 8'h8E;
    endcase
    return c;
  endfunction

  assign scan_tc  = (scan_cnt == SCAN_TC);
  assign blink_tc = (blink_cnt == BLINK_TC);

  // Digit scan: hold each position SCAN_DIV cycles, latch the value on the 7->0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt   <= '0;
      idx        <= 3'd0;
      shadow     <= 24'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (scan_tc) begin
        scan_cnt <= '0;
        idx      <= idx + 3'd1;
        if (idx == 3'd7) begin
          frame_done <= 1'b1;
          shadow     <= seg_value;
        end
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  // Blink half-period timer; parked at zero whenever blink is disabled.
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt <= '0;
    end else if (blink_tc) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Blink phase state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_ON;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Blink phase next state: forced ON while disabled, toggles on timer wrap.
  always_comb begin
    phase_nxt = phase;
    if (!blink_en) begin
      phase_nxt = PH_ON;
    end else if (blink_tc) begin
      phase_nxt = (phase == PH_ON) ? PH_OFF : PH_ON;
    end
  end

  // Blink phase output: whether digits may be lit this cycle.
  always_comb begin
    disp_on = (phase == PH_ON);
  end

  // Select the current nibble and whether everything above it is zero.
  always_comb begin
    nibble  = 4'h0;
    lz_dark = 1'b0;
    case (idx)
      3'd0: nibble = shadow[3:0];
      3'd1: begin
        nibble  = shadow[7:4];
        lz_dark = (shadow[23:4] == 20'h0);
      end
      3'd2: begin
        nibble  = shadow[11:8];
        lz_dark = (shadow[23:8] == 16'h0);
      end
      3'd3: begin
        nibble  = shadow[15:12];
        lz_dark = (shadow[23:12] == 12'h0);
      end
      3'd4: begin
        nibble  = shadow[19:16];
        lz_dark = (shadow[23:16] == 8'h0);
      end
      3'd5: begin
        nibble  = shadow[23:20];
        lz_dark = (shadow[23:20] == 4'h0);
      end
      default: begin
        nibble  = 4'h0;
        lz_dark = 1'b0;
      end
    endcase
  end

  // Compose the next anode/cathode pattern; positions 6 and 7 are always dark.
  always_comb begin
    an_nxt = 8'hFF;
    ca_nxt = 8'hFF;
    if (disp_on && (idx < 3'd6) && !(blank_lz && lz_dark)) begin
      an_nxt = ~(8'b1 << idx);
      ca_nxt = hex_ca(nibble);
    end
  end

  // Registered pin drive, one cycle behind idx, glitch-free at the pads.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an <= 8'hFF;
      seg_ca <= 8'hFF;
    end else begin
      seg_an <= an_nxt;
      seg_ca <= ca_nxt;
    end
  end

endmodule
